noc_switch_control: RTL and testbench
=====================================

Name: noc_switch_control

Overview:
- Per-router switch allocator for the Hermes-style mesh PE.
- Takes packet requests from the 5 input buffers (EAST, WEST, NORTH, SOUTH, LOCAL) and round-robin arbitrates among them.
- Computes the XY route from the header flit and reserves the chosen output port until the sender reports packet end.
- Drives the crossbar select lines; one instance per router inside each PE.

Parameters:
- FLIT_WIDTH, 32, flit/header width; address fields are FLIT_WIDTH/4 bits wide.
- ADDRESS, 0, router address: x at [FLIT_WIDTH/2-1:FLIT_WIDTH/4], y at [FLIT_WIDTH/4-1:0].
- NPORT, 5, port count; indices EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_i  input  NPORT  input buffer i holds a header flit and requests routing.
- header_i  input  NPORT*FLIT_WIDTH  header flit of input i (slice i), stable while req_i[i] is high.
- free_i  input  NPORT  one-cycle pulse: output o finished sending the packet tail.
- ack_o  output  NPORT  one-cycle grant pulse to input i.
- sel_o  output  NPORT*3  for output o, the index of the input driving it.
- out_busy_o  output  NPORT  output o is allocated; qualifies sel_o slice o.
- in_busy_o  output  NPORT  input i currently owns an output.

Behaviour:
- reset low, asynchronously:
  - state goes to IDLE.
  - ack_o, out_busy_o, in_busy_o, sel_o all 0.
  - rr pointer = LOCAL (4), so the first search starts at EAST.
  - Reset mid-allocation drops any pending grant; connections in progress are discarded.
- Eligible input: req_i[i]=1 and in_busy_o[i]=0. Requests from busy inputs are ignored.
- IDLE:
  - If any input is eligible, pick the first eligible index scanning ptr+1, ptr+2, ... modulo NPORT.
  - Latch that index and its header, set ptr = selected index, go to ROUTE.
  - Otherwise stay in IDLE.
- ROUTE (one cycle):
  - Target tx = header[FLIT_WIDTH/2-1:FLIT_WIDTH/4], ty = header[FLIT_WIDTH/4-1:0]; local lx, ly come from ADDRESS. All compares are unsigned.
  - Output selection:
    - tx>lx gives EAST; tx<lx gives WEST.
    - Otherwise ty>ly gives NORTH; ty<ly gives SOUTH.
    - Otherwise LOCAL.
  - If the chosen output is free:
    - set out_busy_o[o], sel_o[o]=input, in_busy_o[input], and record owner[input]=o;
    - go to GRANT.
  - If the chosen output is busy: no grant, go to IDLE. The pointer has already advanced, so other inputs are not starved; the blocked input retries on its next turn.
- GRANT (one cycle): ack_o[input]=1, then go to IDLE.
- Latency: request sampled in IDLE at edge n → ack_o high from edge n+2 to n+3. Minimum spacing between grants is 3 cycles.
- free_i[o]:
  - At the edge, clears out_busy_o[o] and in_busy_o[sel_o[o]]; sel_o[o] keeps its last value.
  - free_i on a non-busy output is ignored.
  - Multiple free_i bits in the same cycle are all honoured.
- Free vs. ROUTE in the same cycle for the same output: the free takes effect this edge; the ROUTE check sees the pre-edge busy value, so the request is refused and retried.
- A free of an input's output during ROUTE for that same input cannot happen, because a busy input is not eligible.
- The requester drops req_i[i] after ack_o[i]. A req_i[i] still high while in_busy_o[i]=1 is ignored.
- The header flit is not consumed by this block; the buffer forwards it after the ack.

Test Plan:
- ADDRESS=0x0101; LOCAL req, header 0x0201 → ack_o[4] 2 cycles after sampling; out_busy_o[EAST]=1; sel_o[EAST]=4; in_busy_o[4]=1.
- Headers 0x0001 → WEST; 0x0102 → NORTH; 0x0100 → SOUTH; 0x0101 → LOCAL. Each one is acked, then freed with free_i.
- All 5 inputs request at once with distinct destinations → grants in order EAST, WEST, NORTH, SOUTH, LOCAL, spaced 3 cycles apart.
- EAST busy (owned by WEST input); NORTH input requests 0x0201 → no ack, and the pointer moves on. free_i[EAST] pulse → NORTH acked on its next turn; sel_o[EAST]=2.
- free_i[EAST] in the same cycle as ROUTE targets EAST → refused, then granted on retry; out_busy_o[EAST] never shows a double owner.
- reset asserted low during ROUTE with 2 outputs busy → all outputs 0 immediately. After release, a fresh LOCAL request is granted normally.

Source files
------------

// File: rtl/noc_switch_control.sv
// Switch allocator for a Hermes-style mesh router: round-robin picks a requesting
// input buffer, routes its header XY-first, and holds the output until freed.
module noc_switch_control #(
  parameter int                    FLIT_WIDTH = 32,
  parameter logic [FLIT_WIDTH-1:0] ADDRESS    = '0,
  parameter int                    NPORT      = 5
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NPORT-1:0]            req_i,
  input  logic [NPORT*FLIT_WIDTH-1:0] header_i,
  input  logic [NPORT-1:0]            free_i,
  output logic [NPORT-1:0]            ack_o,
  output logic [NPORT*3-1:0]          sel_o,
  output logic [NPORT-1:0]            out_busy_o,
  output logic [NPORT-1:0]            in_busy_o,
  output logic [1:0]                  fsm_state
);

  localparam int AW = FLIT_WIDTH / 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUTE = 2'd1;
  localparam logic [1:0] S_GRANT = 2'd2;

  localparam logic [2:0] P_EAST  = 3'd0;
  localparam logic [2:0] P_WEST  = 3'd1;
  localparam logic [2:0] P_NORTH = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_LOCAL = 3'd4;

  logic [1:0]            state;
  logic [2:0]            ptr;
  logic [2:0]            cur_in;
  logic [FLIT_WIDTH-1:0] cur_hdr;
  logic [2:0]            sel_r [NPORT];

  logic [NPORT-1:0]      eligible;
  logic                  found;
  logic [2:0]            pick;
  logic [2:0]            scan_idx;
  logic [FLIT_WIDTH-1:0] pick_hdr;
  logic [AW-1:0]         tx, ty, lx, ly;
  logic [2:0]            route_out;

  assign fsm_state = state;

  // Round-robin scan starts one past the last selected input.
  always_comb begin
    eligible = req_i & ~in_busy_o;
    found    = 1'b0;
    pick     = ptr;
    scan_idx = '0;
    for (int k = 1; k <= NPORT; k++) begin
      scan_idx = 3'((int'(ptr) + k) % NPORT);
      if (!found && eligible[scan_idx]) begin
        found = 1'b1;
        pick  = scan_idx;
      end
    end
  end

  always_comb begin
    pick_hdr = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (pick == 3'(i)) pick_hdr = header_i[i*FLIT_WIDTH +: FLIT_WIDTH];
    end
  end

  // XY routing: resolve the x axis fully before moving in y.
  always_comb begin
    tx = cur_hdr[2*AW-1:AW];
    ty = cur_hdr[AW-1:0];
    lx = ADDRESS[2*AW-1:AW];
    ly = ADDRESS[AW-1:0];
    if (tx > lx)      route_out = P_EAST;
    else if (tx < lx) route_out = P_WEST;
    else if (ty > ly) route_out = P_NORTH;
    else if (ty < ly) route_out = P_SOUTH;
    else              route_out = P_LOCAL;
  end

  always_comb begin
    sel_o = '0;
    for (int o = 0; o < NPORT; o++) sel_o[o*3 +: 3] = sel_r[o];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= 3'(NPORT - 1);
      cur_in     <= '0;
      cur_hdr    <= '0;
      ack_o      <= '0;
      out_busy_o <= '0;
      in_busy_o  <= '0;
      for (int o = 0; o < NPORT; o++) sel_r[o] <= '0;
    end else begin
      ack_o <= '0;
      // Frees land first; ROUTE below only grants outputs that were free before this edge.
      for (int o = 0; o < NPORT; o++) begin
        if (free_i[o] && out_busy_o[o]) begin
          out_busy_o[o]       <= 1'b0;
          in_busy_o[sel_r[o]] <= 1'b0;
        end
      end
      case (state)
        S_IDLE: begin
          if (found) begin
            cur_in  <= pick;
            cur_hdr <= pick_hdr;
            ptr     <= pick;
            state   <= S_ROUTE;
          end
        end
        S_ROUTE: begin
          if (!out_busy_o[route_out]) begin
            out_busy_o[route_out] <= 1'b1;
            sel_r[route_out]      <= cur_in;
            in_busy_o[cur_in]     <= 1'b1;
            state                 <= S_GRANT;
          end else begin
            state <= S_IDLE;
          end
        end
        S_GRANT: begin
          ack_o[cur_in] <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_switch_control.sv
// Directed bench for noc_switch_control with ADDRESS=0x0101: grants are queued as
// {input, output} and a negedge monitor checks each ack against the queue head.
module tb_noc_switch_control;

  localparam int FW = 32;
  localparam int NP = 5;

  logic             clock;
  logic             reset;
  logic [NP-1:0]    req_i;
  logic [NP*FW-1:0] header_i;
  logic [NP-1:0]    free_i;
  logic [NP-1:0]    ack_o;
  logic [NP*3-1:0]  sel_o;
  logic [NP-1:0]    out_busy_o;
  logic [NP-1:0]    in_busy_o;
  logic [1:0]       fsm_state;

  int checks   = 0;
  int failures = 0;

  logic [5:0] exp_q[$];

  noc_switch_control #(.FLIT_WIDTH(FW), .ADDRESS(32'h0101), .NPORT(NP)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_i      (req_i),
    .header_i   (header_i),
    .free_i     (free_i),
    .ack_o      (ack_o),
    .sel_o      (sel_o),
    .out_busy_o (out_busy_o),
    .in_busy_o  (in_busy_o),
    .fsm_state  (fsm_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] sel_of(input int o);
    logic [NP*3-1:0] s;
    s = sel_o;
    return s[o*3 +: 3];
  endfunction

  // Monitor: every ack pops the queue head and checks grant and crossbar state.
  always @(negedge clock) begin
    if (reset && ack_o != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack got=0x%0h exp=none", ack_o);
      end else begin
        logic [5:0] e;
        logic [4:0] ea;
        e  = exp_q.pop_front();
        ea = 5'b1 << e[5:3];
        chk("mon_ack", 32'(ack_o), 32'(ea));
        chk("mon_out_busy", 32'(out_busy_o[e[2:0]]), 32'd1);
        chk("mon_sel", 32'(sel_of(int'(e[2:0]))), 32'(e[5:3]));
        chk("mon_in_busy", 32'(in_busy_o[e[5:3]]), 32'd1);
      end
    end
  end

  task automatic do_reset();
    reset    = 1'b0;
    req_i    = '0;
    free_i   = '0;
    header_i = '0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic drive_req(input int idx, input logic [31:0] hdr);
    header_i[idx*FW +: FW] = hdr;
    req_i[idx] = 1'b1;
  endtask

  // exp_k = 0 accepts any latency within the bound.
  task automatic wait_ack(input int idx, input int exp_k, input string name);
    int k;
    bit seen;
    k = 0;
    seen = 0;
    while (!seen && k < 40) begin
      @(negedge clock);
      k++;
      if (ack_o[idx]) seen = 1;
    end
    req_i[idx] = 1'b0;
    checks++;
    if (!seen || (exp_k != 0 && k != exp_k)) begin
      failures++;
      $display("FAIL %s ack_latency got=%0d exp=%0d seen=%0d", name, k, exp_k, seen);
    end
  endtask

  task automatic pulse_free(input logic [NP-1:0] mask);
    free_i = mask;
    @(negedge clock);
    free_i = '0;
  endtask

  initial begin
    logic [31:0] hdrs [4];
    logic [2:0]  outs [4];
    hdrs = '{32'h0001, 32'h0102, 32'h0100, 32'h0101};
    outs = '{3'd1, 3'd2, 3'd3, 3'd4};

    do_reset();
    chk("reset_out_busy", 32'(out_busy_o), 32'h0);
    chk("reset_in_busy", 32'(in_busy_o), 32'h0);
    chk("reset_sel", 32'(sel_o), 32'h0);
    chk("reset_ack", 32'(ack_o), 32'h0);
    chk("reset_state", 32'(fsm_state), 32'd0);

    // LOCAL input to 0x0201 goes east.
    exp_q.push_back({3'd4, 3'd0});
    drive_req(4, 32'h0201);
    wait_ack(4, 3, "local_to_east");
    chk("t1_out_busy", 32'(out_busy_o), 32'h01);
    chk("t1_sel_east", 32'(sel_of(0)), 32'd4);
    chk("t1_in_busy", 32'(in_busy_o), 32'h10);
    pulse_free(5'b00001);
    chk("t1_free_out", 32'(out_busy_o), 32'h0);
    chk("t1_free_in", 32'(in_busy_o), 32'h0);

    // Remaining directions from the LOCAL input.
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({3'd4, outs[i]});
      drive_req(4, hdrs[i]);
      wait_ack(4, 3, "dir_route");
      chk("dir_out_busy", 32'(out_busy_o), 32'(5'b1 << outs[i]));
      pulse_free(5'b1 << outs[i]);
      chk("dir_freed", 32'(out_busy_o | in_busy_o), 32'h0);
    end

    // All five request together: round robin from EAST, 3 cycles apart.
    do_reset();
    drive_req(0, 32'h0201);
    drive_req(1, 32'h0001);
    drive_req(2, 32'h0102);
    drive_req(3, 32'h0100);
    drive_req(4, 32'h0101);
    for (int i = 0; i < NP; i++) exp_q.push_back({3'(i), 3'(i)});
    for (int i = 0; i < NP; i++) wait_ack(i, 3, "rr_order");
    chk("rr_all_busy", 32'(out_busy_o), 32'h1f);
    chk("rr_sel", 32'(sel_o), 32'({3'd4, 3'd3, 3'd2, 3'd1, 3'd0}));
    pulse_free(5'b11111);
    chk("rr_multi_free_out", 32'(out_busy_o), 32'h0);
    chk("rr_multi_free_in", 32'(in_busy_o), 32'h0);

    // EAST held by WEST input; NORTH input is refused until the free.
    exp_q.push_back({3'd1, 3'd0});
    drive_req(1, 32'h0201);
    wait_ack(1, 3, "west_to_east");
    drive_req(2, 32'h0201);
    repeat (10) @(negedge clock);
    chk("blocked_out_busy", 32'(out_busy_o), 32'h01);
    chk("blocked_in_busy", 32'(in_busy_o), 32'h02);
    exp_q.push_back({3'd2, 3'd0});
    pulse_free(5'b00001);
    wait_ack(2, 0, "north_retry");
    chk("retry_sel_east", 32'(sel_of(0)), 32'd2);
    chk("retry_in_busy", 32'(in_busy_o), 32'h04);
    repeat (2) @(negedge clock);

    // Free of EAST lands on the same edge as ROUTE to EAST: refused, then retried.
    drive_req(3, 32'h0201);
    @(negedge clock);
    chk("race_in_route", 32'(fsm_state), 32'd1);
    free_i = 5'b00001;
    @(negedge clock);
    free_i = '0;
    chk("race_freed", 32'(out_busy_o), 32'h0);
    chk("race_no_ack", 32'(ack_o), 32'h0);
    exp_q.push_back({3'd3, 3'd0});
    wait_ack(3, 3, "race_retry");
    chk("race_single_owner", 32'(out_busy_o), 32'h01);
    chk("race_sel", 32'(sel_of(0)), 32'd3);

    // Two outputs busy, then reset during ROUTE.
    exp_q.push_back({3'd4, 3'd1});
    drive_req(4, 32'h0001);
    wait_ack(4, 3, "local_to_west");
    chk("pre_reset_busy", 32'(out_busy_o), 32'h03);
    drive_req(0, 32'h0102);
    @(negedge clock);
    chk("pre_reset_route", 32'(fsm_state), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_out_busy", 32'(out_busy_o), 32'h0);
    chk("async_in_busy", 32'(in_busy_o), 32'h0);
    chk("async_sel", 32'(sel_o), 32'h0);
    chk("async_state", 32'(fsm_state), 32'd0);
    req_i = '0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    exp_q.push_back({3'd4, 3'd4});
    drive_req(4, 32'h0101);
    wait_ack(4, 3, "post_reset_local");
    chk("post_reset_busy", 32'(out_busy_o), 32'h10);

    repeat (3) @(negedge clock);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
